// File: rtl/semi_auto_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : semi_auto_pkg
//  Purpose  : Shared types and helpers for the semi-automatic navigator.
//             Holds the FSM state encoding, the detector/button bit indices,
//             and open_exits(), which turns debounced walls into an
//             open-exit mask.
//  Revision : 1.0 - initial release
// ============================================================================
package semi_auto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FWD    = 3'd2,
        ST_TURN_L = 3'd3,
        ST_TURN_R = 3'd4,
        ST_TURN_U = 3'd5,
        ST_SETTLE = 3'd6
    } state_t;

    // Bit positions inside det / btn vectors {front,back,left,right}
    localparam int FRONT = 3;
    localparam int BACK  = 2;
    localparam int LEFT  = 1;
    localparam int RIGHT = 0;

    // Bit positions inside the open_exits() mask {front,left,right}
    localparam int OPEN_F = 2;
    localparam int OPEN_L = 1;
    localparam int OPEN_R = 0;

    // A detector reads 1 for a wall, so an exit is open where the bit is 0.
    // The back side is never a forward choice and is not part of the mask.
    function automatic logic [2:0] open_exits(input logic [3:0] det_q);
        return {~det_q[FRONT], ~det_q[LEFT], ~det_q[RIGHT]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : det_debounce
//  Purpose  : Per-channel detector debouncer. A channel output changes only
//             after its raw input has differed from it on DEBOUNCE
//             consecutive tick samples. Any matching sample restarts the run.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             tick           - sample enable
//             raw[WIDTH]     - raw detector inputs
//             q[WIDTH]       - debounced outputs (reset to all walls = 1)
//  Revision : 1.0 - initial release
// ============================================================================
module det_debounce #(
    parameter int DEBOUNCE = 3,
    parameter int WIDTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] q
);

    // The stability counter clears as it reaches DEBOUNCE, so it only ever
    // holds 0..DEBOUNCE-1 and fits in 4 bits for DEBOUNCE <= 15.
    localparam logic [3:0] c_last = 4'(DEBOUNCE - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [3:0] r_cnt;
        logic       r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_q   <= 1'b1;
            end else if (tick) begin
                if (raw[i] != r_q) begin
                    if (r_cnt == c_last) begin
                        r_q   <= raw[i];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign q[i] = r_q;
    end : g_chan

endmodule
`default_nettype wire

// File: rtl/semi_auto_nav.sv
`default_nettype none
// ============================================================================
//  Module   : semi_auto_nav
//  Purpose  : Semi-automatic car navigator. Runs forward along corridors,
//             stops at junctions, dead ends and front walls, then executes a
//             button-selected (or auto-picked) timed turn followed by a
//             forced-forward settle run-out.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             tick_1ms            - one-cycle timing enable
//             enable              - semi-auto enable; 0 forces IDLE
//             det[3:0]            - raw detectors {front,back,left,right}
//             btn[3:0]            - level buttons {front,back,left,right}
//             state[2:0]          - current FSM state
//             move_forward/backward, turn_left/right - motor commands
//             count[CNT_W]        - tick counter of the timed states
//             turn_done           - one-cycle pulse as a turn completes
//  Revision : 1.0 - initial release
// ============================================================================
module semi_auto_nav
    import semi_auto_pkg::*;
#(
    parameter int TURN_TICKS   = 900,
    parameter int SETTLE_TICKS = 200,
    parameter int DEBOUNCE     = 3,
    parameter int AUTO_PICK    = 0,
    parameter int CNT_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1ms,
    input  logic             enable,
    input  logic [3:0]       det,
    input  logic [3:0]       btn,
    output logic [2:0]       state,
    output logic             move_forward,
    output logic             move_backward,
    output logic             turn_left,
    output logic             turn_right,
    output logic [CNT_W-1:0] count,
    output logic             turn_done
);

    localparam logic [CNT_W-1:0] c_turn_last   = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_uturn_last  = CNT_W'(2 * TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_TICKS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_turn_last;
    logic             w_turn_fin;
    logic [3:0]       r_btn_prev;
    logic [3:0]       w_edge;
    logic [3:0]       w_det_q;
    logic [2:0]       w_open;
    logic             r_move_forward;
    logic             r_turn_left;
    logic             r_turn_right;
    logic             r_turn_done;

    det_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .WIDTH    (4)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_1ms),
        .raw  (det),
        .q    (w_det_q)
    );

    assign w_edge      = btn & ~r_btn_prev;
    assign w_open      = open_exits(w_det_q);
    assign w_turn_last = (r_state == ST_TURN_U) ? c_uturn_last : c_turn_last;

    // ------------------------------------------------------------------
    // Next-state / next-count logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_turn_fin  = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_WAIT;

                ST_WAIT: begin
                    // Highest-priority edge toward an open side wins;
                    // edges toward walls are dropped.
                    if (w_edge[FRONT] && w_open[OPEN_F]) begin
                        w_state_nxt = ST_SETTLE;
                    end else if (w_edge[LEFT] && w_open[OPEN_L]) begin
                        w_state_nxt = ST_TURN_L;
                    end else if (w_edge[RIGHT] && w_open[OPEN_R]) begin
                        w_state_nxt = ST_TURN_R;
                    end else if (w_edge[BACK]) begin
                        w_state_nxt = ST_TURN_U;
                    end else if (AUTO_PICK != 0) begin
                        case (w_open)
                            3'b100:  w_state_nxt = ST_SETTLE;
                            3'b010:  w_state_nxt = ST_TURN_L;
                            3'b001:  w_state_nxt = ST_TURN_R;
                            3'b000:  w_state_nxt = ST_TURN_U;
                            default: w_state_nxt = ST_WAIT;
                        endcase
                    end
                end

                // Keep driving only in a plain corridor.
                ST_FWD: begin
                    if (w_det_q[FRONT] || !w_det_q[LEFT] || !w_det_q[RIGHT]) begin
                        w_state_nxt = ST_WAIT;
                    end
                end

                ST_TURN_L, ST_TURN_R, ST_TURN_U: begin
                    if (tick_1ms) begin
                        if (r_count == w_turn_last) begin
                            w_state_nxt = ST_SETTLE;
                            w_turn_fin  = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end

                // A front wall aborts the run-out before the timer can expire.
                ST_SETTLE: begin
                    if (w_det_q[FRONT]) begin
                        w_state_nxt = ST_WAIT;
                    end else if (tick_1ms) begin
                        if (r_count == c_settle_last) begin
                            w_state_nxt = ST_FWD;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end

                default: w_state_nxt = ST_IDLE;
            endcase

            if (w_state_nxt != r_state) begin
                w_count_nxt = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, counter and registered Moore outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_btn_prev     <= '0;
            r_move_forward <= 1'b0;
            r_turn_left    <= 1'b0;
            r_turn_right   <= 1'b0;
            r_turn_done    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_btn_prev     <= btn;
            r_move_forward <= (w_state_nxt == ST_FWD) || (w_state_nxt == ST_SETTLE);
            r_turn_left    <= (w_state_nxt == ST_TURN_L) || (w_state_nxt == ST_TURN_U);
            r_turn_right   <= (w_state_nxt == ST_TURN_R);
            r_turn_done    <= w_turn_fin;
        end
    end

    assign state         = r_state;
    assign count         = r_count;
    assign move_forward  = r_move_forward;
    assign move_backward = 1'b0;
    assign turn_left     = r_turn_left;
    assign turn_right    = r_turn_right;
    assign turn_done     = r_turn_done;

endmodule
`default_nettype wire

// File: tb/tb_semi_auto_nav.sv
`default_nettype none
// ============================================================================
//  Module   : tb_semi_auto_nav
//  Purpose  : Self-checking bench for semi_auto_nav. Two instances share the
//             stimulus, one with AUTO_PICK=0 and one with AUTO_PICK=1, and
//             are compared each cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_semi_auto_nav;

    localparam int TT    = 4;
    localparam int ST    = 3;
    localparam int DEB   = 2;
    localparam int CNT_W = 12;

    // State codes as numbered in the block description
    localparam int S_IDLE = 0, S_WAIT = 1, S_FWD = 2, S_TL = 3,
                   S_TR = 4, S_TU = 5, S_SET = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1ms;
    logic       enable;
    logic [3:0] det;
    logic [3:0] btn;

    logic [2:0]       d_state [2];
    logic             d_mf [2];
    logic             d_mb [2];
    logic             d_tl [2];
    logic             d_tr [2];
    logic [CNT_W-1:0] d_cnt [2];
    logic             d_done [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    semi_auto_nav #(
        .TURN_TICKS(TT), .SETTLE_TICKS(ST), .DEBOUNCE(DEB),
        .AUTO_PICK(0), .CNT_W(CNT_W)
    ) u_dut0 (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .enable(enable),
        .det(det), .btn(btn), .state(d_state[0]),
        .move_forward(d_mf[0]), .move_backward(d_mb[0]),
        .turn_left(d_tl[0]), .turn_right(d_tr[0]),
        .count(d_cnt[0]), .turn_done(d_done[0])
    );

    semi_auto_nav #(
        .TURN_TICKS(TT), .SETTLE_TICKS(ST), .DEBOUNCE(DEB),
        .AUTO_PICK(1), .CNT_W(CNT_W)
    ) u_dut1 (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .enable(enable),
        .det(det), .btn(btn), .state(d_state[1]),
        .move_forward(d_mf[1]), .move_backward(d_mb[1]),
        .turn_left(d_tl[1]), .turn_right(d_tr[1]),
        .count(d_cnt[1]), .turn_done(d_done[1])
    );

    // ---------------- behavioural reference model ----------------
    int         m_st   [2];
    int         m_cnt  [2];
    logic [3:0] m_dq   [2];
    int         m_run  [2][4];
    logic [3:0] m_bp   [2];
    logic       m_done [2];

    task automatic model_step(input int k, input bit ap);
        logic [3:0] dq;
        logic [3:0] e;
        bit f, l, r;
        int len, nopen;
        if (rst) begin
            m_st[k] = S_IDLE; m_cnt[k] = 0; m_dq[k] = 4'hF;
            for (int b = 0; b < 4; b++) m_run[k][b] = 0;
            m_bp[k] = 4'h0; m_done[k] = 1'b0;
        end else begin
            dq = m_dq[k];
            e  = btn & ~m_bp[k];
            m_bp[k] = btn;
            if (tick_1ms) begin
                for (int b = 0; b < 4; b++) begin
                    if (det[b] != dq[b]) begin
                        m_run[k][b] = m_run[k][b] + 1;
                        if (m_run[k][b] == DEB) begin
                            m_dq[k][b] = det[b];
                            m_run[k][b] = 0;
                        end
                    end else begin
                        m_run[k][b] = 0;
                    end
                end
            end
            f = !dq[3]; l = !dq[1]; r = !dq[0];
            m_done[k] = 1'b0;
            if (!enable) begin
                m_st[k] = S_IDLE; m_cnt[k] = 0;
            end else if (m_st[k] == S_IDLE) begin
                m_st[k] = S_WAIT;
            end else if (m_st[k] == S_WAIT) begin
                nopen = int'(f) + int'(l) + int'(r);
                if (e[3] && f)      m_st[k] = S_SET;
                else if (e[1] && l) m_st[k] = S_TL;
                else if (e[0] && r) m_st[k] = S_TR;
                else if (e[2])      m_st[k] = S_TU;
                else if (ap && nopen == 0) m_st[k] = S_TU;
                else if (ap && nopen == 1) m_st[k] = f ? S_SET : (l ? S_TL : S_TR);
            end else if (m_st[k] == S_FWD) begin
                if (!(f && !l && !r)) m_st[k] = S_WAIT;
            end else if (m_st[k] == S_TL || m_st[k] == S_TR || m_st[k] == S_TU) begin
                len = (m_st[k] == S_TU) ? 2 * TT : TT;
                if (tick_1ms) begin
                    if (m_cnt[k] + 1 == len) begin
                        m_st[k] = S_SET; m_cnt[k] = 0; m_done[k] = 1'b1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end else if (m_st[k] == S_SET) begin
                if (!f) begin
                    m_st[k] = S_WAIT; m_cnt[k] = 0;
                end else if (tick_1ms) begin
                    if (m_cnt[k] + 1 == ST) begin
                        m_st[k] = S_FWD; m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input int k,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        logic [3:0] mot;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step(0, 1'b0);
            model_step(1, 1'b1);
            #1;
            for (int k = 0; k < 2; k++) begin
                mot = {m_st[k] == S_FWD || m_st[k] == S_SET, 1'b0,
                       m_st[k] == S_TL || m_st[k] == S_TU, m_st[k] == S_TR};
                check("state", k, 32'(d_state[k]), 32'(m_st[k]));
                check("count", k, 32'(d_cnt[k]), 32'(m_cnt[k]));
                check("motors", k, 32'({d_mf[k], d_mb[k], d_tl[k], d_tr[k]}), 32'(mot));
                check("turn_done", k, 32'(d_done[k]), 32'(m_done[k]));
            end
        end
    endtask

    task automatic pulse(input logic [3:0] b);
        btn = b; cyc(1); btn = 4'h0;
    endtask

    initial begin
        int hold;
        logic [3:0] pats [6];
        pats[0] = 4'b0011; pats[1] = 4'b1010; pats[2] = 4'b1011;
        pats[3] = 4'b1001; pats[4] = 4'b0110; pats[5] = 4'b1000;

        rst = 1'b1; tick_1ms = 1'b1; enable = 1'b0; det = 4'b0110; btn = 4'h0;
        cyc(2);
        rst = 1'b0; enable = 1'b1;
        cyc(4);
        // front exit into settle, then corridor
        pulse(4'b1000); det = 4'b0011; cyc(8);
        // junction ahead, then right turn
        det = 4'b1010; cyc(4);
        pulse(4'b0001); cyc(9);
        // dead end: blocked left ignored, back gives U-turn
        det = 4'b1011; cyc(4);
        pulse(4'b0010); cyc(2);
        pulse(4'b0100); cyc(14);
        // auto-pick cases (second instance)
        det = 4'b1001; cyc(12);
        det = 4'b1011; cyc(20);
        // enable drop mid TURN_L
        det = 4'b1001; enable = 1'b0; cyc(1); enable = 1'b1; cyc(4);
        enable = 1'b0; cyc(1); enable = 1'b1; cyc(1);
        pulse(4'b0010); cyc(2);
        enable = 1'b0; cyc(1); enable = 1'b1; cyc(3);
        // reset mid SETTLE
        det = 4'b0011; cyc(3);
        pulse(4'b1000); cyc(1);
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(3);

        // randomized phase
        for (int it = 0; it < 600; it++) begin
            det  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pats[$urandom_range(0, 5)];
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 3) == 0) btn = 4'(1 << $urandom_range(0, 3));
                else                           btn = 4'h0;
                enable = ($urandom_range(0, 59) != 0);
                rst    = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
        end
        rst = 1'b0; enable = 1'b1; btn = 4'h0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
